// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 16;
    localparam int PC_INCR      = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch FSM that drives PC_next and holds the fetched word for decode.
// Latency: imem read in REQ, capture in RESP, inst_valid on the cycle after; 1 word per 3 cycles.
// Backpressure: VALID holds inst/inst_pc stable until inst_ready; redirect preempts any non-IDLE state.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              IF_rst,
    input  logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_next,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         capture;

    assign imem_addr = PC;

    always_comb begin
        state_d = state_q;
        PC_next = PC;
        imem_en = 1'b0;
        capture = 1'b0;
        if (IF_rst) begin
            state_d = IDLE;
            PC_next = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = REQ;
                end
                REQ: begin
                    imem_en = 1'b1;
                    state_d = RESP;
                end
                RESP: begin
                    capture = 1'b1;
                    PC_next = PC + ADDR_W'(PC_INCR);
                    state_d = VALID;
                end
                VALID: begin
                    if (inst_ready) begin
                        state_d = REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // A redirect drops whatever is in flight or held and restarts at the target.
            if (redirect && (state_q != IDLE)) begin
                capture = 1'b0;
                PC_next = redirect_pc;
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (IF_rst) begin
            state_q    <= IDLE;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            inst_valid <= (state_d == VALID);
            if (capture) begin
                inst    <= imem_rdata;
                inst_pc <= PC;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a local PC register and synchronous ROM model.
module tb_inst_fetch;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          IF_rst;
    logic [AW-1:0] PC;
    logic [AW-1:0] PC_next;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          inst_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .IF_rst      (IF_rst),
        .PC          (PC),
        .PC_next     (PC_next),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready)
    );

    // ROM contents: word at address a is A001 + a (so 0..3 hold A001..A004).
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return 16'hA001 + a;
    endfunction

    // PC register shares the reset net with the fetch stage.
    always_ff @(posedge clk) begin
        if (IF_rst) PC <= '0;
        else        PC <= PC_next;
    end

    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= rom(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks REQ, RESP, VALID from an IDLE or VALID cycle and checks the delivered word.
    task automatic expect_fetch(input string tag, input logic [AW-1:0] addr);
        tick();
        check({tag, "_req_en"}, 32'(imem_en), 32'd1);
        check({tag, "_req_addr"}, 32'(imem_addr), 32'(addr));
        check({tag, "_req_nv"}, 32'(inst_valid), 32'd0);
        tick();
        check({tag, "_resp_nv"}, 32'(inst_valid), 32'd0);
        check({tag, "_resp_pcn"}, 32'(PC_next), 32'(addr + 16'd1));
        tick();
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_inst"}, 32'(inst), 32'(rom(addr)));
        check({tag, "_pc"}, 32'(inst_pc), 32'(addr));
    endtask

    initial begin
        IF_rst      = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", 32'(inst), 32'd0);
        check("rst_pc", 32'(inst_pc), 32'd0);
        check("rst_pcnext", 32'(PC_next), 32'd0);
        check("rst_en", 32'(imem_en), 32'd0);

        // Sequential fetch with decode always ready.
        IF_rst = 1'b0;
        #1;
        check("idle_en", 32'(imem_en), 32'd0);
        expect_fetch("seq0", 16'd0);
        expect_fetch("seq1", 16'd1);
        expect_fetch("seq2", 16'd2);
        expect_fetch("seq3", 16'd3);

        // Decode stalls for 5 cycles in VALID.
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(inst_valid), 32'd1);
            check("stall_inst", 32'(inst), 32'(rom(16'd3)));
            check("stall_pcnext", 32'(PC_next), 32'(PC));
            check("stall_en", 32'(imem_en), 32'd0);
        end
        inst_ready = 1'b1;
        #1;
        check("unstall_pcnext", 32'(PC_next), 32'd4);
        expect_fetch("after_stall", 16'd4);

        // Redirect during RESP of address 5.
        tick();
        check("r5_req_addr", 32'(imem_addr), 32'd5);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        check("rresp_pcnext", 32'(PC_next), 32'h0040);
        tick();
        redirect = 1'b0;
        check("rresp_req_addr", 32'(imem_addr), 32'h0040);
        check("rresp_req_nv", 32'(inst_valid), 32'd0);
        tick();
        check("rresp_resp_nv", 32'(inst_valid), 32'd0);
        tick();
        check("rresp_valid", 32'(inst_valid), 32'd1);
        check("rresp_pc", 32'(inst_pc), 32'h0040);
        check("rresp_inst", 32'(inst), 32'(rom(16'h0040)));

        // Redirect during VALID while decode is not ready.
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        check("rvalid_pcnext", 32'(PC_next), 32'h0100);
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        check("rvalid_drop", 32'(inst_valid), 32'd0);
        check("rvalid_req_addr", 32'(imem_addr), 32'h0100);
        tick();
        tick();
        check("rvalid_valid", 32'(inst_valid), 32'd1);
        check("rvalid_pc", 32'(inst_pc), 32'h0100);

        // Wrap from 0xFFFF to 0x0000.
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        check("wrap_req_addr", 32'(imem_addr), 32'hFFFF);
        tick();
        check("wrap_resp_pcnext", 32'(PC_next), 32'h0000);
        tick();
        check("wrap_ffff_pc", 32'(inst_pc), 32'hFFFF);
        check("wrap_ffff_inst", 32'(inst), 32'(rom(16'hFFFF)));
        expect_fetch("wrap0", 16'h0000);

        // Reset while holding a word in VALID.
        inst_ready = 1'b0;
        tick();
        check("prerst_valid", 32'(inst_valid), 32'd1);
        IF_rst = 1'b1;
        #1;
        check("rstc_pcnext", 32'(PC_next), 32'd0);
        check("rstc_en", 32'(imem_en), 32'd0);
        tick();
        check("mrst_valid", 32'(inst_valid), 32'd0);
        check("mrst_inst", 32'(inst), 32'd0);
        check("mrst_pc", 32'(inst_pc), 32'd0);
        check("mrst_pcnext", 32'(PC_next), 32'd0);
        IF_rst     = 1'b0;
        inst_ready = 1'b1;
        expect_fetch("restart", 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage paired with the `PC` register. Each cycle it computes `PC_next`, which the `PC` register loads on every clock edge. It issues a read to the synchronous instruction memory at the current PC, captures the returned word, and presents it to decode with a valid/ready handshake. A redirect input from execute overrides sequential fetch and squashes the in-flight or held instruction.

## Interface
- `ADDR_W`, 16, PC / instruction-memory word-address width
- `DATA_W`, 16, instruction word width

- `clk` input 1 — single clock for the block
- `IF_rst` input 1 — synchronous, active-high reset; tied to the same reset net as `PC_rst` at top level
- `PC` input ADDR_W — current PC from the `PC` register
- `PC_next` output ADDR_W — next PC, loaded by the `PC` register every edge
- `imem_en` output 1 — instruction memory read enable
- `imem_addr` output ADDR_W — read address; combinational copy of `PC`
- `imem_rdata` input DATA_W — read data, valid exactly 1 cycle after `imem_en`
- `redirect` input 1 — taken branch / jump from execute
- `redirect_pc` input ADDR_W — redirect target
- `inst` output DATA_W — fetched instruction
- `inst_pc` output ADDR_W — address `inst` was fetched from
- `inst_valid` output 1 — `inst` / `inst_pc` valid
- `inst_ready` input 1 — decode accepts this cycle

## Operation
- Four-state FSM:
  - IDLE: one cycle after reset.
  - REQ: `imem_en`=1, `PC_next`=`PC`.
  - RESP: capture `inst`<=`imem_rdata` and `inst_pc`<=`PC`; `PC_next`=`PC`+1.
  - VALID: `inst_valid`=1; `PC_next`=`PC`.
- Transitions:
  - IDLE→REQ unconditionally.
  - REQ→RESP.
  - RESP→VALID.
  - VALID→REQ when `inst_ready`; otherwise stay in VALID with `inst` and `inst_pc` stable.
- Redirect has priority in every state except IDLE.
  - `PC_next`=`redirect_pc` in that cycle.
  - Next state is REQ.
  - In RESP, the returned data is discarded and `inst_valid` stays 0.
  - In VALID, `inst_valid` drops the following cycle.
  - In REQ, the outstanding read is ignored and re-issued at the new PC.
- Redirect in IDLE is ignored; `PC_next`=`PC`.
- Redirect together with `inst_valid`&`inst_ready`: the transfer counts. Decode has consumed the word, and squashing it is the pipeline's responsibility downstream.
- Arithmetic is ADDR_W-bit modulo: `PC`=16'hFFFF gives `PC_next`=16'h0000, with no flag.
- `imem_en` is 0 outside REQ. `imem_addr` always equals `PC`.

## Timing
- Reset, with `IF_rst` sampled high on an edge:
  - State goes to IDLE.
  - `inst_valid`, `inst` and `inst_pc` are 0.
  - `PC_next` and `imem_en` read 0 while `IF_rst` is high.
- Reset mid-operation aborts any state. Held data is lost and no partial handshake is completed.
- First fetch: `imem_en` is high in the second cycle after reset deasserts.
- Fetch latency: REQ at cycle t, RESP at t+1, `inst_valid` at t+2.
- Throughput: one instruction per 3 cycles when decode is always ready.
- `inst_valid`, `inst` and `inst_pc` are registered, with no combinational path from `inst_ready` or `redirect`. `PC_next` and `imem_en` are combinational from state, `PC` and `redirect`.
- Redirect-to-valid latency: redirect at cycle t; `PC`=`redirect_pc` at t+1 (REQ); `inst_valid` at t+3.

## Structure
- Shared package `fetch_pkg` holds:
  - the fetch state enum (IDLE, REQ, RESP, VALID) with 2-bit encoding;
  - `ADDR_W` and `DATA_W` defaults;
  - `PC_INCR` = 1.
- No sub-module. The block is one FSM plus the instruction/PC holding registers. It is instantiated beside `PC` with `PC_next` wired directly into it.

## Test plan
- Reset, then ROM[0..3]=A001,A002,A003,A004 with `inst_ready`=1 → `inst`/`inst_pc` = A001/0, A002/1, A003/2, A004/3, with `inst_valid` spaced 3 cycles apart and first asserted 4 cycles after reset release.
- `inst_ready`=0 for 5 cycles in VALID → `inst_valid` held and `inst` stable, `PC_next`=`PC`, `imem_en`=0. Ready then rises → REQ at `PC`+1 the next cycle.
- `redirect`=1 with `redirect_pc`=0x0040 during RESP of address 5 → word at 5 never presented; next `inst_valid` shows `inst_pc`=0x0040 three cycles after the redirect.
- `redirect` during VALID with `inst_ready`=0 → `inst_valid` low the next cycle; following delivery has `inst_pc`=`redirect_pc`.
- `redirect_pc`=0xFFFF → instruction at 0xFFFF delivered, then `inst_pc`=0x0000 (wrap).
- `IF_rst` asserted during VALID with `inst_ready`=0 → next cycle `inst_valid`=0, `inst`=0, `PC_next`=0 while held; restart fetches address 0.
